// File: rtl/mpsoc_wb_ext_pkg.sv
// Shared definitions for the external Wishbone responder: cycle/burst type codes,
// the responder FSM state type and the burst address sequencing helper.
// Build option: MPSOC_WB_EXT_BURST_EN adds the BURST state for incrementing bursts.
package mpsoc_wb_ext_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACK   = 2'd2
`ifdef MPSOC_WB_EXT_BURST_EN
        ,
        BURST = 2'd3
`endif
    } state_e;

    // Wrapping bursts only step the low index bits so the beat stays inside its aligned block.
    function automatic logic [31:0] nextBurstIdx(input logic [31:0] idx, input logic [1:0] bte);
        logic [31:0] nxt;
        nxt = idx;
        case (bte)
            BTE_WRAP4:  nxt[1:0] = idx[1:0] + 2'd1;
            BTE_WRAP8:  nxt[2:0] = idx[2:0] + 3'd1;
            BTE_WRAP16: nxt[3:0] = idx[3:0] + 4'd1;
            default:    nxt      = idx + 32'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mpsoc_wb_ext_ram.sv
// Backing store for the external responder: single port, byte-enable write,
// combinational read. Contents are never reset.
module mpsoc_wb_ext_ram
    import mpsoc_wb_ext_pkg::*;
#(
    parameter int DW    = 32,
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem [WORDS];

    // Only the lanes whose select bit is set are written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DW/8; b++) begin
                if (sel_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mpsoc_wb_ext_responder.sv
// Wishbone slave with a decoded memory window, programmable wait states and
// ack/err termination. Out-of-window accesses terminate with err and touch nothing.
// Build option: MPSOC_WB_EXT_BURST_EN enables incrementing/wrapping bursts;
// without it every access is handled as a classic cycle.
module mpsoc_wb_ext_responder
    import mpsoc_wb_ext_pkg::*;
#(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   wb_ext_adr_i,
    input  logic [DW-1:0]   wb_ext_dat_i,
    input  logic [DW/8-1:0] wb_ext_sel_i,
    input  logic            wb_ext_we_i,
    input  logic            wb_ext_cyc_i,
    input  logic            wb_ext_stb_i,
    input  logic            wb_ext_cab_i,
    input  logic [2:0]      wb_ext_cti_i,
    input  logic [1:0]      wb_ext_bte_i,
    output logic            wb_ext_ack_o,
    output logic            wb_ext_err_o,
    output logic            wb_ext_rty_o,
    output logic [DW-1:0]   wb_ext_dat_o
);

    localparam int               IDX_W       = AW - 2;
    localparam int               RAM_AW      = $clog2(MEM_WORDS);
    localparam logic [IDX_W-1:0] WORDS_LIMIT = IDX_W'(MEM_WORDS);
    localparam logic [3:0]       WAIT_LOAD   = 4'(WAIT_STATES);

    state_e           state_q, state_d;
    logic [3:0]       waitCnt_q, waitCnt_d;
    logic [IDX_W-1:0] wordIdx_q, wordIdx_d;
    logic             we_q, we_d;

    logic [AW-1:0]    adrOffset;
    logic [IDX_W-1:0] reqIdx;
    logic             busReq;
    logic             inRange;
    logic             termActive;
    logic             ramWe;
    logic [DW-1:0]    ramRdata;
    logic             unusedInputs;

    // Addresses below the base wrap to huge offsets, so one upper-bound compare covers both ends.
    assign adrOffset = wb_ext_adr_i - AW'(BASE_ADDR);
    assign reqIdx    = adrOffset[AW-1:2];
    assign busReq    = wb_ext_cyc_i & wb_ext_stb_i;
    assign inRange   = (wordIdx_q < WORDS_LIMIT);

    // Terminations are gated by the live strobe so a master that backs off never sees a stray ack.
    always_comb begin
        termActive = 1'b0;
        if (busReq) begin
            if (state_q == ACK) termActive = 1'b1;
`ifdef MPSOC_WB_EXT_BURST_EN
            if (state_q == BURST) termActive = 1'b1;
`endif
        end
    end

    assign wb_ext_ack_o = termActive & inRange;
    assign wb_ext_err_o = termActive & ~inRange;
    assign wb_ext_rty_o = 1'b0;
    assign ramWe        = wb_ext_ack_o & we_q;
    assign wb_ext_dat_o = (wb_ext_ack_o && !we_q) ? ramRdata : '0;

    assign unusedInputs = ^{wb_ext_cab_i, wb_ext_cti_i, wb_ext_bte_i, adrOffset[1:0]};

    mpsoc_wb_ext_ram #(
        .DW    (DW),
        .WORDS (MEM_WORDS),
        .AW    (RAM_AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ramWe),
        .sel_i   (wb_ext_sel_i),
        .addr_i  (wordIdx_q[RAM_AW-1:0]),
        .wdata_i (wb_ext_dat_i),
        .rdata_o (ramRdata)
    );

    // State register; reset drops any termination at once and abandons a pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            wordIdx_q <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            wordIdx_q <= wordIdx_d;
            we_q      <= we_d;
        end
    end

    // Next-state logic: latch the request, burn wait states, terminate, then idle or stream beats.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        wordIdx_d = wordIdx_q;
        we_d      = we_q;
        case (state_q)
            IDLE: begin
                if (busReq) begin
                    wordIdx_d = reqIdx;
                    we_d      = wb_ext_we_i;
                    waitCnt_d = WAIT_LOAD;
                    state_d   = (WAIT_STATES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!busReq) begin
                    state_d   = IDLE;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                    if (waitCnt_q <= 4'd1) state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
`ifdef MPSOC_WB_EXT_BURST_EN
                if (busReq && inRange && (wb_ext_cti_i == CTI_INCR)) begin
                    state_d   = BURST;
                    wordIdx_d = IDX_W'(nextBurstIdx(32'(wordIdx_q), wb_ext_bte_i));
                end
`endif
            end
`ifdef MPSOC_WB_EXT_BURST_EN
            BURST: begin
                if (!wb_ext_cyc_i) begin
                    state_d = IDLE;
                end else if (wb_ext_stb_i) begin
                    if (!inRange || (wb_ext_cti_i == CTI_END)) begin
                        state_d = IDLE;
                    end else begin
                        wordIdx_d = IDX_W'(nextBurstIdx(32'(wordIdx_q), wb_ext_bte_i));
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mpsoc_wb_ext_responder.sv
// Self-checking bench: three responders (0, 3 and 5 wait states) share one bus,
// each selected by its own cyc line, and are compared against a word-array model.
module tb_mpsoc_wb_ext_responder;

    localparam int MEM_WORDS = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] datIn;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cab;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [2:0]  cycV;
    logic        ackV [3];
    logic        errV [3];
    logic        rtyV [3];
    logic [31:0] datV [3];

    int          testsRun;
    int          testsFailed;
    int          wsOf [3];
    logic [31:0] refMem [3][MEM_WORDS];

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One responder per wait-state setting, all hanging off the same bus.
    for (genvar g = 0; g < 3; g++) begin : gDut
        mpsoc_wb_ext_responder #(
            .AW          (32),
            .DW          (32),
            .MEM_WORDS   (MEM_WORDS),
            .BASE_ADDR   (32'h0),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .wb_ext_adr_i (adr),
            .wb_ext_dat_i (datIn),
            .wb_ext_sel_i (sel),
            .wb_ext_we_i  (we),
            .wb_ext_cyc_i (cycV[g]),
            .wb_ext_stb_i (stb),
            .wb_ext_cab_i (cab),
            .wb_ext_cti_i (cti),
            .wb_ext_bte_i (bte),
            .wb_ext_ack_o (ackV[g]),
            .wb_ext_err_o (errV[g]),
            .wb_ext_rty_o (rtyV[g]),
            .wb_ext_dat_o (datV[g])
        );
    end

    // Safety net so a stuck bus can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference write: merge the selected byte lanes into the model word.
    task automatic modelWrite(input int d, input int idx, input logic [31:0] wd, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) refMem[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // Drives one single-beat cycle and reports latency and termination as seen by the master.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] s, input logic w, input logic [2:0] c,
                                 input logic holdExtra, output int lat, output logic gotAck,
                                 output logic gotErr, output logic [31:0] rdata,
                                 output logic termAfter);
        @(negedge clk);
        adr = a; datIn = wd; sel = s; we = w; stb = 1'b1; cti = c; bte = 2'b00;
        cycV = 3'b000; cycV[d] = 1'b1;
        lat = 0; gotAck = 1'b0; gotErr = 1'b0; rdata = '0; termAfter = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ackV[d] || errV[d]) begin
                lat = k; gotAck = ackV[d]; gotErr = errV[d]; rdata = datV[d];
                break;
            end
        end
        if (holdExtra) begin
            @(negedge clk);
            termAfter = ackV[d] | errV[d];
        end else begin
            @(posedge clk);
            #1;
        end
        stb = 1'b0; we = 1'b0; cycV = 3'b000; cti = 3'b000;
    endtask

    // Classic access with expectations taken from the address window and the model.
    task automatic classicOp(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] s, input logic w, input string tag);
        int          lat;
        logic        gotAck, gotErr, termAfter, inR;
        logic [31:0] rdata, expData;
        int          idx;
        inR     = (a < 32'(4 * MEM_WORDS));
        idx     = int'(a >> 2);
        expData = (inR && !w) ? refMem[d][idx] : 32'h0;
        applyStimulus(d, a, wd, s, w, 3'b000, 1'b0, lat, gotAck, gotErr, rdata, termAfter);
        checkOutput({tag, "_lat"}, lat, 1 + wsOf[d]);
        checkOutput({tag, "_ack"}, 32'(gotAck), 32'(inR));
        checkOutput({tag, "_err"}, 32'(gotErr), 32'(!inR));
        checkOutput({tag, "_dat"}, rdata, expData);
        if (inR && w) modelWrite(d, idx, wd, s);
    endtask

`ifdef MPSOC_WB_EXT_BURST_EN
    // Read burst; the model walks the index with plain block arithmetic.
    task automatic burstRead(input int d, input logic [31:0] a, input logic [1:0] b,
                             input int beats, input string tag);
        int   idx, lat, blk;
        logic inR;
        idx = int'(a >> 2);
        blk = (b == 2'b00) ? 0 : (2 << b);
        @(negedge clk);
        adr = a; we = 1'b0; sel = 4'hF; stb = 1'b1; bte = b;
        cti = (beats == 1) ? 3'b111 : 3'b010;
        cycV = 3'b000; cycV[d] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ackV[d] || errV[d]) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, "_lat"}, lat, 1 + wsOf[d]);
        for (int beat = 1; beat <= beats; beat++) begin
            if (beat > 1) @(negedge clk);
            inR = (idx < MEM_WORDS);
            checkOutput({tag, "_ack"}, 32'(ackV[d]), 32'(inR));
            checkOutput({tag, "_err"}, 32'(errV[d]), 32'(!inR));
            checkOutput({tag, "_dat"}, datV[d], inR ? refMem[d][idx] : 32'h0);
            if (!inR) break;
            idx = (blk == 0) ? idx + 1 : (idx / blk) * blk + (idx + 1) % blk;
            if (beat == beats - 1) begin
                @(posedge clk);
                #1;
                cti = 3'b111;
            end
        end
        @(negedge clk);
        checkOutput({tag, "_idle_ack"}, 32'(ackV[d]), 32'h0);
        checkOutput({tag, "_idle_err"}, 32'(errV[d]), 32'h0);
        stb = 1'b0; cycV = 3'b000; cti = 3'b000; bte = 2'b00;
    endtask
`endif

    // Directed scenarios followed by randomized traffic, all in one linear sequence.
    initial begin
        int          lat;
        logic        gotAck, gotErr, termAfter;
        logic [31:0] rdata;

        testsRun = 0; testsFailed = 0;
        wsOf = '{0, 3, 5};
        rst = 1'b0; adr = '0; datIn = '0; sel = '0; we = 1'b0; stb = 1'b0;
        cab = 1'b0; cti = 3'b000; bte = 2'b00; cycV = 3'b000;

        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset_ack", 32'(ackV[d]), 32'h0);
            checkOutput("reset_err", 32'(errV[d]), 32'h0);
            checkOutput("reset_rty", 32'(rtyV[d]), 32'h0);
            checkOutput("reset_dat", datV[d], 32'h0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;

        classicOp(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, "req021_wr");
        classicOp(0, 32'h10, 32'h0, 4'hF, 1'b0, "req021_rd");
        applyStimulus(0, 32'h10, 32'h0, 4'hF, 1'b0, 3'b000, 1'b1, lat, gotAck, gotErr, rdata, termAfter);
        checkOutput("pulse_lat", lat, 1);
        checkOutput("pulse_dat", rdata, 32'hDEADBEEF);
        checkOutput("pulse_width", 32'(termAfter), 32'h0);

        classicOp(1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b1, "req022_init");
        classicOp(1, 32'h20, 32'h11223344, 4'b0101, 1'b1, "req022_wr");
        classicOp(1, 32'h20, 32'h0, 4'hF, 1'b0, "req022_rd");

        classicOp(0, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1, "req023_init");
        classicOp(0, 32'h4000, 32'h0, 4'hF, 1'b0, "req023_rd");
        classicOp(0, 32'h4000, 32'h12345678, 4'hF, 1'b1, "req023_wr");
        classicOp(0, 32'h0, 32'h0, 4'hF, 1'b0, "req023_alias");

        classicOp(2, 32'h80, 32'h0000AAAA, 4'hF, 1'b1, "req025_init");
        @(negedge clk);
        adr = 32'h80; datIn = 32'h55555555; sel = 4'hF; we = 1'b1; stb = 1'b1; cycV = 3'b100;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("req025_ack_at_rst", 32'(ackV[2]), 32'h0);
        checkOutput("req025_err_at_rst", 32'(errV[2]), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("req025_ack_in_rst", 32'(ackV[2]), 32'h0);
            checkOutput("req025_err_in_rst", 32'(errV[2]), 32'h0);
        end
        stb = 1'b0; we = 1'b0; cycV = 3'b000; rst = 1'b1;
        classicOp(2, 32'h80, 32'h0, 4'hF, 1'b0, "req025_rd");

        for (int d = 0; d < 3; d++) begin
            for (int i = 64; i < 96; i++) begin
                classicOp(d, 32'(4 * i), $urandom, 4'hF, 1'b1, "rand_init");
            end
        end
        for (int n = 0; n < 60; n++) begin
            int          d;
            logic [31:0] a;
            d = int'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) a = 32'h1000 + 4 * $urandom_range(0, 1023) + $urandom_range(0, 3);
            else a = 4 * $urandom_range(64, 95) + $urandom_range(0, 3);
            classicOp(d, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand_op");
        end

`ifdef MPSOC_WB_EXT_BURST_EN
        for (int i = 12; i < 16; i++) classicOp(0, 32'(4 * i), $urandom, 4'hF, 1'b1, "req024_init");
        burstRead(0, 32'h38, 2'b01, 4, "req024");
        classicOp(0, 32'hFF8, $urandom, 4'hF, 1'b1, "lin_end_init0");
        classicOp(0, 32'hFFC, $urandom, 4'hF, 1'b1, "lin_end_init1");
        burstRead(0, 32'hFF8, 2'b00, 3, "lin_end");
        for (int n = 0; n < 6; n++) begin
            logic [1:0] b;
            int         startIdx;
            b = 2'($urandom_range(0, 3));
            startIdx = (b == 2'b00) ? int'($urandom_range(64, 88)) : int'($urandom_range(64, 95));
            burstRead(int'($urandom_range(0, 2)), 32'(4 * startIdx), b,
                      int'($urandom_range(2, 6)), "rand_burst");
        end

        @(negedge clk);
        adr = 32'h100; we = 1'b0; sel = 4'hF; stb = 1'b1; cti = 3'b010; bte = 2'b00; cycV = 3'b010;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ackV[1]) begin
                lat = k;
                break;
            end
        end
        checkOutput("req026_lat", lat, 4);
        checkOutput("req026_dat1", datV[1], refMem[1][64]);
        @(negedge clk);
        checkOutput("req026_ack2", 32'(ackV[1]), 32'h1);
        checkOutput("req026_dat2", datV[1], refMem[1][65]);
        @(posedge clk);
        #1;
        stb = 1'b0; cycV = 3'b000; cti = 3'b000;
        @(negedge clk);
        checkOutput("req026_ack_drop", 32'(ackV[1]), 32'h0);
        classicOp(1, 32'h100, 32'h0, 4'hF, 1'b0, "req026_rd");
`else
        applyStimulus(1, 32'h100, 32'h0, 4'hF, 1'b0, 3'b010, 1'b1, lat, gotAck, gotErr, rdata, termAfter);
        checkOutput("noburst_lat", lat, 4);
        checkOutput("noburst_ack", 32'(gotAck), 32'h1);
        checkOutput("noburst_dat", rdata, refMem[1][64]);
        checkOutput("noburst_gap", 32'(termAfter), 32'h0);
`endif

        for (int d = 0; d < 3; d++) checkOutput("rty_const", 32'(rtyV[d]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
